// File: rtl/mistral_ff_pipe_pkg.sv
// Shared definitions for the mistral_ff_pipe register chain: the occupancy
// counter width and the per-edge control priority decode.
package mistral_ff_pkg;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // What one rising edge does to the chain, highest priority first.
  typedef enum logic [1:0] {
    CTRL_HOLD,
    CTRL_SCLR,
    CTRL_SLOAD,
    CTRL_DATA
  } ctrl_e;

  // ENA gates everything, then SCLR beats SLOAD, which beats DATAIN.
  function automatic ctrl_e decode_ctrl(input logic ena, input logic sclr,
                                        input logic sload);
    if (!ena)      return CTRL_HOLD;
    else if (sclr) return CTRL_SCLR;
    else if (sload) return CTRL_SLOAD;
    else           return CTRL_DATA;
  endfunction

endpackage

// File: rtl/mistral_ff_pipe_if.sv
// Data/control bundle of the register chain. The master drives the controls
// and stage-0 data and observes the chain tail; the slave is the chain.
//
// Flow control: there is no backpressure. ENA=1 advances the whole chain by
// one stage on the rising edge; VALID_IN (or SLOAD) marks the word entering
// stage 0 as valid, and VALID_OUT marks Q as valid. ENA=0 freezes every stage.
interface mistral_ff_pipe_if
  import mistral_ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OW = occ_width(DEPTH);

  logic             ENA;
  logic             SCLR;
  logic             SLOAD;
  logic [WIDTH-1:0] SDATA;
  logic [WIDTH-1:0] DATAIN;
  logic             VALID_IN;
  logic [WIDTH-1:0] Q;
  logic             VALID_OUT;
  logic [OW-1:0]    OCCUPANCY;

  modport master (
    output ENA, SCLR, SLOAD, SDATA, DATAIN, VALID_IN,
    input  Q, VALID_OUT, OCCUPANCY
  );

  modport slave (
    input  ENA, SCLR, SLOAD, SDATA, DATAIN, VALID_IN,
    output Q, VALID_OUT, OCCUPANCY
  );
endinterface

// File: rtl/mistral_ff_pipe_stage.sv
// One stage of the chain: WIDTH data bits plus a valid bit, with clock
// enable, synchronous clear to zero and asynchronous clear to INIT.
module mistral_ff_stage #(
  parameter int               WIDTH     = 8,
  parameter bit               ACLR_USED = 1'b1,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             ena,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             v_out
);

  // In the sync-only variant the clear is tied off so the cell stays ABC9-eligible.
  logic rst_n;
  assign rst_n = ACLR_USED ? aclr : 1'b1;

  logic [WIDTH-1:0] data_r  = INIT;
  logic             valid_r = 1'b0;

  // Stage register: async clear to INIT, sync clear to zero, else shift in when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= INIT;
      valid_r <= 1'b0;
    end else if (ena) begin
      if (sclr) begin
        data_r  <= '0;
        valid_r <= 1'b0;
      end else begin
        data_r  <= d;
        valid_r <= v_in;
      end
    end
  end

  assign q     = data_r;
  assign v_out = valid_r;

endmodule

// File: rtl/mistral_ff_pipe.sv
// DEPTH-stage WIDTH-bit register chain with Mistral-style per-cell controls,
// a valid-bit pipeline and a registered occupancy counter.
module mistral_ff_pipe
  import mistral_ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter bit               ACLR_USED = 1'b1,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input logic              CLK,
  input logic              ACLR,
  mistral_ff_pipe_if.slave bus
);

  localparam int OW = occ_width(DEPTH);

  ctrl_e            ctrl;
  logic [WIDTH-1:0] head_d;
  logic             head_v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             rst_n;
  logic [OW-1:0]    occ_r = '0;

  assign ctrl  = decode_ctrl(bus.ENA, bus.SCLR, bus.SLOAD);
  assign rst_n = ACLR_USED ? ACLR : 1'b1;

  // Stage-0 input: SLOAD substitutes SDATA and always creates a valid entry.
  assign head_d = (ctrl == CTRL_SLOAD) ? bus.SDATA : bus.DATAIN;
  assign head_v = bus.SLOAD | bus.VALID_IN;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    if (i == 0) begin : g_head
      assign d_in = head_d;
      assign v_in = head_v;
    end else begin : g_tail
      assign d_in = data[i-1];
      assign v_in = valid[i-1];
    end
    mistral_ff_stage #(
      .WIDTH(WIDTH), .ACLR_USED(ACLR_USED), .INIT(INIT)
    ) u_stage (
      .clk  (CLK),
      .aclr (ACLR),
      .ena  (bus.ENA),
      .sclr (bus.SCLR),
      .d    (d_in),
      .v_in (v_in),
      .q    (data[i]),
      .v_out(valid[i])
    );
  end

  // Occupancy tracks entries minus exits so it always equals the valid-bit count.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else begin
      case (ctrl)
        CTRL_HOLD: occ_r <= occ_r;
        CTRL_SCLR: occ_r <= '0;
        default:   occ_r <= occ_r + OW'(head_v) - OW'(valid[DEPTH-1]);
      endcase
    end
  end

  assign bus.Q         = data[DEPTH-1];
  assign bus.VALID_OUT = valid[DEPTH-1];
  assign bus.OCCUPANCY = occ_r;

endmodule

// File: tb/tb_mistral_ff_pipe.sv
// Bench for mistral_ff_pipe: a DEPTH=4 async-clear instance and a DEPTH=1
// sync-only instance driven with identical stimulus, each compared against
// a queue model of the chain.
module tb_mistral_ff_pipe;

  localparam logic [7:0] INIT_A = 8'hA5;
  localparam logic [7:0] INIT_B = 8'h5A;
  localparam int         DEP_A  = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  mistral_ff_pipe_if #(.WIDTH(8), .DEPTH(DEP_A)) ia ();
  mistral_ff_pipe_if #(.WIDTH(8), .DEPTH(1))     ib ();

  mistral_ff_pipe #(.WIDTH(8), .DEPTH(DEP_A), .ACLR_USED(1'b1), .INIT(INIT_A))
    u_a (.CLK(clk), .ACLR(aclr), .bus(ia.slave));
  mistral_ff_pipe #(.WIDTH(8), .DEPTH(1), .ACLR_USED(1'b0), .INIT(INIT_B))
    u_b (.CLK(clk), .ACLR(aclr), .bus(ib.slave));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // Reference chains: element 0 is the newest word, the last element is Q.
  logic [7:0] qa_d[$];
  bit         qa_v[$];
  logic [7:0] qb_d[$];
  bit         qb_v[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill_a(input logic [7:0] v);
    qa_d = {};
    qa_v = {};
    for (int i = 0; i < DEP_A; i++) begin
      qa_d.push_back(v);
      qa_v.push_back(1'b0);
    end
  endtask

  task automatic compare_all();
    int pa;
    pa = 0;
    foreach (qa_v[i]) pa += int'(qa_v[i]);
    check("a_q",       32'(ia.Q),         32'(qa_d[DEP_A-1]));
    check("a_valid",   32'(ia.VALID_OUT), 32'(qa_v[DEP_A-1]));
    check("a_occ",     32'(ia.OCCUPANCY), 32'(pa));
    check("a_occ_max", 32'(ia.OCCUPANCY <= DEP_A), 32'd1);
    check("b_q",       32'(ib.Q),         32'(qb_d[0]));
    check("b_valid",   32'(ib.VALID_OUT), 32'(qb_v[0]));
    check("b_occ",     32'(ib.OCCUPANCY), 32'(qb_v[0]));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit ena, input bit sclr, input bit sload,
                       input logic [7:0] sdata, input logic [7:0] din, input bit vin);
    ia.ENA = ena; ia.SCLR = sclr; ia.SLOAD = sload;
    ia.SDATA = sdata; ia.DATAIN = din; ia.VALID_IN = vin;
    ib.ENA = ena; ib.SCLR = sclr; ib.SLOAD = sload;
    ib.SDATA = sdata; ib.DATAIN = din; ib.VALID_IN = vin;
  endtask

  // One clock: apply inputs, advance the models at the edge, compare at negedge.
  task automatic step(input bit ena, input bit sclr, input bit sload,
                      input logic [7:0] sdata, input logic [7:0] din, input bit vin);
    logic [7:0] nd;
    bit         nv;
    drive(ena, sclr, sload, sdata, din, vin);
    @(posedge clk);
    nd = sload ? sdata : din;
    nv = sload | vin;
    if (!aclr) begin
      model_fill_a(INIT_A);
    end else if (ena) begin
      if (sclr) begin
        model_fill_a(8'h00);
      end else begin
        qa_d.push_front(nd); void'(qa_d.pop_back());
        qa_v.push_front(nv); void'(qa_v.pop_back());
      end
    end
    if (ena) begin
      if (sclr) begin
        qb_d[0] = 8'h00; qb_v[0] = 1'b0;
      end else begin
        qb_d[0] = nd;    qb_v[0] = nv;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    model_fill_a(INIT_A);
    qb_d.push_back(INIT_B);
    qb_v.push_back(1'b0);

    // Reset state of both instances, then an edge while still in reset.
    @(negedge clk);
    compare_all();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h77, 1'b1);
    aclr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Stream 1..5, then a 3-cycle ENA=0 gap, then continue 6..8 and drain.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b0, 8'h00, 8'hEE, 1'b1);
    for (int i = 6; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'(i), 1'b1);
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // SLOAD overrides DATAIN and creates a valid entry.
    step(1'b1, 1'b0, 1'b1, 8'h3C, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0);

    // Fill, then SCLR+SLOAD with ENA=0 (no effect) and with ENA=1 (clear to 0).
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h40 + i), 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h99, 8'h88, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h99, 8'h88, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Fill, then assert ACLR between edges: A clears at once, B ignores it.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'hC0 + i), 1'b1);
    #2;
    aclr = 1'b0;
    #1;
    model_fill_a(INIT_A);
    compare_all();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'hD1, 1'b1);
    aclr = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'hD2 + i), 1'b1);

    // Randomised mix of all controls.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 4) == 0), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
